// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeper.
// The lap-hold feature is selected with the STOPWATCH_LAP_EN macro (see top).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int DIGIT_MAX = 9;
  localparam int SEXT_MAX  = 5;

  // Whole MM:SS.CC value, most significant digit first so that it reads as
  // a hex literal 24'hMMSSCC.
  typedef struct packed {
    bcd_t m_tens;
    bcd_t m_ones;
    bcd_t s_tens;
    bcd_t s_ones;
    bcd_t cs_tens;
    bcd_t cs_ones;
  } sw_time_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch carry chain: counts 0..MAX on en, wraps to 0
// and raises tc in the same cycle so the next digit can be enabled.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       tc
);

  localparam bcd_t MAX_Q = bcd_t'(MAX);

  bcd_t count;
  logic at_max;

  // A digit at or above its maximum is treated as the maximum, so an
  // out-of-range value recovers on the next increment instead of sticking.
  assign at_max = (count >= MAX_Q);

  // Digit register: synchronous clear has priority over counting.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would race with the neighbouring digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + 4'd1;
    end
  end

  assign q  = count;
  assign tc = en && at_max;

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch timekeeper: counts 100 Hz tick enables into BCD MM:SS.CC under a
// run/pause/clear state machine driven by debounced one-cycle button pulses.
// Optional macro STOPWATCH_LAP_EN adds a lap-hold copy of the digit outputs;
// without it the lap input is accepted but has no effect.
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int MIN_TENS_MAX  = 5,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_100hz,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       running,
  output logic       rollover
);

  localparam state_t RESET_STATE = START_RUNNING ? RUN : IDLE;

  state_t   state_q;
  state_t   state_d;
  logic     clr_digits;
  logic     count_en;

  logic [3:0] cs_ones_q, cs_tens_q, s_ones_q, s_tens_q, m_ones_q, m_tens_q;
  logic       tc_cs_ones, tc_cs_tens, tc_s_ones, tc_s_tens, tc_m_ones, wrap;
  sw_time_t   live;
  sw_time_t   shown;
  logic       rollover_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and digit clear. In RUN start_stop beats clear; elsewhere
  // clear beats start_stop.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_digits = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          clr_digits = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start_stop) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d    = IDLE;
          clr_digits = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A tick counts only when it is sampled in RUN, even if RUN is being left.
  assign count_en = tick_100hz && (state_q == RUN);

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_cs_ones (
    .clk(clk), .reset(reset), .en(count_en), .clr(clr_digits),
    .q(cs_ones_q), .tc(tc_cs_ones)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_cs_tens (
    .clk(clk), .reset(reset), .en(tc_cs_ones), .clr(clr_digits),
    .q(cs_tens_q), .tc(tc_cs_tens)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_s_ones (
    .clk(clk), .reset(reset), .en(tc_cs_tens), .clr(clr_digits),
    .q(s_ones_q), .tc(tc_s_ones)
  );

  bcd_digit_cnt #(.MAX(SEXT_MAX)) u_s_tens (
    .clk(clk), .reset(reset), .en(tc_s_ones), .clr(clr_digits),
    .q(s_tens_q), .tc(tc_s_tens)
  );

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_m_ones (
    .clk(clk), .reset(reset), .en(tc_s_tens), .clr(clr_digits),
    .q(m_ones_q), .tc(tc_m_ones)
  );

  bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_m_tens (
    .clk(clk), .reset(reset), .en(tc_m_ones), .clr(clr_digits),
    .q(m_tens_q), .tc(wrap)
  );

  assign live = {m_tens_q, m_ones_q, s_tens_q, s_ones_q, cs_tens_q, cs_ones_q};

  // Rollover pulse lines up with the cycle the digits read 00:00.00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= wrap;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic     hold_q;
  sw_time_t held_q;

  // Lap hold: lap in RUN captures the live value (re-capturing while already
  // held); lap in PAUSE or any effective clear releases the hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else if (clr_digits) begin
      hold_q <= 1'b0;
    end else if (lap && (state_q == RUN)) begin
      hold_q <= 1'b1;
      held_q <= live;
    end else if (lap && (state_q == PAUSE)) begin
      hold_q <= 1'b0;
    end
  end

  assign shown = hold_q ? held_q : live;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign shown      = live;
`endif

  assign cs_ones  = shown.cs_ones;
  assign cs_tens  = shown.cs_tens;
  assign s_ones   = shown.s_ones;
  assign s_tens   = shown.s_tens;
  assign m_ones   = shown.m_ones;
  assign m_tens   = shown.m_tens;
  assign running  = (state_q == RUN);
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Directed self-checking bench for stopwatch_timekeeper. Inputs change on the
// falling edge and outputs are sampled on the falling edge after the rising
// edge that acted on them. Times are written as 24'hMMSSCC.
module tb_stopwatch_timekeeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_100hz;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
  logic       running;
  logic       rollover;

  int checks   = 0;
  int failures = 0;

  logic [23:0] preload_val;
  logic [23:0] exp_lap;

  stopwatch_timekeeper dut (
    .clk(clk), .reset(reset), .tick_100hz(tick_100hz),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
    .m_ones(m_ones), .m_tens(m_tens), .running(running), .rollover(rollover)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] shown();
    return {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};
  endfunction

  // Called just after a falling edge; applies one cycle of inputs.
  task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
    tick_100hz = t;
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(negedge clk);
    tick_100hz = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Deposits preload_val into the digit registers between clock edges.
  task preload();
    force dut.u_cs_ones.count = preload_val[3:0];
    force dut.u_cs_tens.count = preload_val[7:4];
    force dut.u_s_ones.count  = preload_val[11:8];
    force dut.u_s_tens.count  = preload_val[15:12];
    force dut.u_m_ones.count  = preload_val[19:16];
    force dut.u_m_tens.count  = preload_val[23:20];
    #1;
    release dut.u_cs_ones.count;
    release dut.u_cs_tens.count;
    release dut.u_s_ones.count;
    release dut.u_s_tens.count;
    release dut.u_m_ones.count;
    release dut.u_m_tens.count;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (shown() !== 24'h000000) begin
      failures++; $display("FAIL reset_time: got %h expected %h", shown(), 24'h000000);
    end
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL reset_running: got %b expected 0", running);
    end
    checks++;
    if (rollover !== 1'b0) begin
      failures++; $display("FAIL reset_rollover: got %b expected 0", rollover);
    end
    reset = 1'b1;
    ticks(3);
    checks++;
    if (shown() !== 24'h000000) begin
      failures++; $display("FAIL idle_no_count: got %h expected %h", shown(), 24'h000000);
    end
  endtask

  task automatic test_count();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL start_running: got %b expected 1", running);
    end
    ticks(150);
    checks++;
    if (shown() !== 24'h000150) begin
      failures++; $display("FAIL count_150: got %h expected %h", shown(), 24'h000150);
    end
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL count_running: got %b expected 1", running);
    end
    preload_val = 24'h005999;
    preload();
    ticks(1);
    checks++;
    if (shown() !== 24'h010000) begin
      failures++; $display("FAIL carry_s_tens: got %h expected %h", shown(), 24'h010000);
    end
    preload_val = 24'h095999;
    preload();
    ticks(1);
    checks++;
    if (shown() !== 24'h100000) begin
      failures++; $display("FAIL carry_m_ones: got %h expected %h", shown(), 24'h100000);
    end
    checks++;
    if (rollover !== 1'b0) begin
      failures++; $display("FAIL no_rollover: got %b expected 0", rollover);
    end
  endtask

  task automatic test_wrap();
    preload_val = 24'h595999;
    preload();
    checks++;
    if (shown() !== 24'h595999) begin
      failures++; $display("FAIL preload_max: got %h expected %h", shown(), 24'h595999);
    end
    ticks(1);
    checks++;
    if (shown() !== 24'h000000) begin
      failures++; $display("FAIL wrap_time: got %h expected %h", shown(), 24'h000000);
    end
    checks++;
    if (rollover !== 1'b1) begin
      failures++; $display("FAIL wrap_rollover: got %b expected 1", rollover);
    end
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL wrap_running: got %b expected 1", running);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rollover !== 1'b0) begin
      failures++; $display("FAIL rollover_width: got %b expected 0", rollover);
    end
    ticks(1);
    checks++;
    if (shown() !== 24'h000001) begin
      failures++; $display("FAIL after_wrap: got %h expected %h", shown(), 24'h000001);
    end
  endtask

  task automatic test_pause_tick();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(37);
    checks++;
    if (shown() !== 24'h000037) begin
      failures++; $display("FAIL count_37: got %h expected %h", shown(), 24'h000037);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (shown() !== 24'h000038) begin
      failures++; $display("FAIL tick_with_stop: got %h expected %h", shown(), 24'h000038);
    end
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL paused: got %b expected 0", running);
    end
    ticks(5);
    checks++;
    if (shown() !== 24'h000038) begin
      failures++; $display("FAIL pause_holds: got %h expected %h", shown(), 24'h000038);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (shown() !== 24'h000038) begin
      failures++; $display("FAIL tick_with_resume: got %h expected %h", shown(), 24'h000038);
    end
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL resumed: got %b expected 1", running);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (shown() !== 24'h000038 || running !== 1'b1) begin
      failures++; $display("FAIL clear_in_run: got %h/%b expected %h/1", shown(), running, 24'h000038);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (shown() !== 24'h000000 || running !== 1'b0) begin
      failures++; $display("FAIL clear_in_pause: got %h/%b expected %h/0", shown(), running, 24'h000000);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (shown() !== 24'h000003 || running !== 1'b0) begin
      failures++; $display("FAIL pause_at_3: got %h/%b expected %h/0", shown(), running, 24'h000003);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (shown() !== 24'h000000 || running !== 1'b0) begin
      failures++; $display("FAIL pause_ss_clear: got %h/%b expected %h/0", shown(), running, 24'h000000);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL idle_ss_clear: got %b expected 0", running);
    end
    ticks(2);
    checks++;
    if (shown() !== 24'h000000) begin
      failures++; $display("FAIL idle_after_clear: got %h expected %h", shown(), 24'h000000);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    preload_val = 24'h123456;
    preload();
    ticks(2);
    checks++;
    if (shown() !== 24'h123458) begin
      failures++; $display("FAIL mid_count: got %h expected %h", shown(), 24'h123458);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (shown() !== 24'h000000 || running !== 1'b0 || rollover !== 1'b0) begin
      failures++; $display("FAIL async_reset: got %h/%b/%b expected %h/0/0", shown(), running, rollover, 24'h000000);
    end
    @(negedge clk);
    reset = 1'b1;
    ticks(2);
    checks++;
    if (shown() !== 24'h000000 || running !== 1'b0) begin
      failures++; $display("FAIL reset_to_idle: got %h/%b expected %h/0", shown(), running, 24'h000000);
    end
  endtask

  task automatic test_lap();
`ifdef STOPWATCH_LAP_EN
    exp_lap = 24'h000200;
`else
    exp_lap = 24'h000500;
`endif
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(200);
    checks++;
    if (shown() !== 24'h000200) begin
      failures++; $display("FAIL lap_start: got %h expected %h", shown(), 24'h000200);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(300);
    checks++;
    if (shown() !== exp_lap) begin
      failures++; $display("FAIL lap_hold: got %h expected %h", shown(), exp_lap);
    end
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL lap_running: got %b expected 1", running);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (shown() !== exp_lap) begin
      failures++; $display("FAIL lap_pause: got %h expected %h", shown(), exp_lap);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (shown() !== 24'h000500) begin
      failures++; $display("FAIL lap_release: got %h expected %h", shown(), 24'h000500);
    end
  endtask

  initial begin
    reset       = 1'b0;
    tick_100hz  = 1'b0;
    start_stop  = 1'b0;
    clear       = 1'b0;
    lap         = 1'b0;
    preload_val = '0;
    exp_lap     = '0;
    test_reset();
    test_count();
    test_wrap();
    test_pause_tick();
    test_clear();
    test_async_reset();
    test_lap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
